// File: rtl/aes_seq_ctrl.sv
// aes_seq_ctrl: command-level sequencer for the byte-serial AES core.
// It takes one 128-bit key/data command, streams the key and data bytes into
// the core, pulses start, waits out the core latency, shifts the 16 result
// bytes back and presents them as one 128-bit response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | cmd_ready high, waiting for a command
// S_LDKEY  | 16 cycles of aes_loadkey with key bytes 0..15
// S_LDDATA | 16 cycles of aes_load_shift with data bytes 0..15
// S_START  | one-cycle aes_staenc or aes_stadec pulse
// S_WAIT   | CORE_LAT idle cycles while the core computes
// S_UNLOAD | 16 shift cycles plus DOUT_LAT drain, result bytes captured
// S_RESP   | rsp_valid held until rsp_ready
module aes_seq_ctrl #(
    parameter int CORE_LAT = 13,
    parameter int DOUT_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_dec,
    input  logic         cmd_newkey,
    input  logic [127:0] cmd_key,
    input  logic [127:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         busy,
    output logic [7:0]   aes_din,
    output logic         aes_loadkey,
    output logic         aes_load_shift,
    output logic         aes_staenc,
    output logic         aes_stadec,
    input  logic [7:0]   aes_dout
);

    localparam int UNL_LEN = 16 + DOUT_LAT;
    localparam int WMAX    = (CORE_LAT > UNL_LEN) ? CORE_LAT : UNL_LEN;
    localparam int WW      = $clog2(WMAX + 1);

    localparam logic [WW-1:0] WAIT_TOP  = WW'(CORE_LAT - 1);
    localparam logic [WW-1:0] UNL_TOP   = WW'(UNL_LEN - 1);
    localparam logic [WW-1:0] SHIFT_END = WW'(16);
    localparam logic [WW-1:0] CAP_START = WW'(DOUT_LAT);
    localparam logic [WW-1:0] W_ZERO    = '0;
    localparam logic [WW-1:0] W_ONE     = WW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LDKEY  = 3'd1,
        S_LDDATA = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_UNLOAD = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    state_t         state, state_nx;
    logic [3:0]     cnt, cnt_nx;
    logic [WW-1:0]  wcnt, wcnt_nx;
    logic [127:0]   key_q, key_nx;
    logic [127:0]   data_q, data_nx;
    logic           dec_q, dec_nx;
    logic           key_loaded, key_loaded_nx;
    logic [127:0]   rsp_data_nx;
    logic           rsp_err_nx;

    logic           accept;
    logic [WW-1:0]  unl_idx;
    logic [WW-1:0]  unl_idx_nx;

    logic           cmd_ready_nx;
    logic           rsp_valid_nx;
    logic           busy_nx;
    logic [7:0]     aes_din_nx;
    logic           aes_loadkey_nx;
    logic           aes_load_shift_nx;
    logic           aes_staenc_nx;
    logic           aes_stadec_nx;

    // cmd_ready is only ever high in IDLE, the state check keeps accept local
    assign accept     = cmd_valid && cmd_ready && (state == S_IDLE);
    // unload cycle number counted up from the down-counting wait counter
    assign unl_idx    = UNL_TOP - wcnt;
    assign unl_idx_nx = UNL_TOP - wcnt_nx;

    // next-state, counters, command latch and result capture
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        wcnt_nx       = wcnt;
        key_nx        = key_q;
        data_nx       = data_q;
        dec_nx        = dec_q;
        key_loaded_nx = key_loaded;
        rsp_data_nx   = rsp_data;
        rsp_err_nx    = rsp_err;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    key_nx     = cmd_key;
                    data_nx    = cmd_data;
                    dec_nx     = cmd_dec;
                    cnt_nx     = 4'd0;
                    rsp_err_nx = 1'b0;
                    if (cmd_newkey) begin
                        state_nx = S_LDKEY;
                    end else if (key_loaded) begin
                        state_nx = S_LDDATA;
                    end else begin
                        state_nx    = S_RESP;
                        rsp_err_nx  = 1'b1;
                        rsp_data_nx = '0;
                    end
                end
            end
            S_LDKEY: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    state_nx      = S_LDDATA;
                    key_loaded_nx = 1'b1;
                end
            end
            S_LDDATA: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                state_nx = S_WAIT;
                wcnt_nx  = WAIT_TOP;
            end
            S_WAIT: begin
                if (wcnt == W_ZERO) begin
                    state_nx = S_UNLOAD;
                    wcnt_nx  = UNL_TOP;
                end else begin
                    wcnt_nx = wcnt - W_ONE;
                end
            end
            S_UNLOAD: begin
                // first captured byte ends up in [7:0] after 16 right shifts
                if (unl_idx >= CAP_START) begin
                    rsp_data_nx = {aes_dout, rsp_data[127:8]};
                end
                if (wcnt == W_ZERO) begin
                    state_nx = S_RESP;
                end else begin
                    wcnt_nx = wcnt - W_ONE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // output values for the coming cycle, derived from the next state so
    // every output can be a plain register aligned with its state
    always_comb begin
        cmd_ready_nx      = (state_nx == S_IDLE);
        busy_nx           = (state_nx != S_IDLE);
        rsp_valid_nx      = (state_nx == S_RESP);
        aes_din_nx        = 8'd0;
        aes_loadkey_nx    = 1'b0;
        aes_load_shift_nx = 1'b0;
        aes_staenc_nx     = 1'b0;
        aes_stadec_nx     = 1'b0;

        case (state_nx)
            S_LDKEY: begin
                aes_loadkey_nx = 1'b1;
                aes_din_nx     = key_nx[{cnt_nx, 3'b000} +: 8];
            end
            S_LDDATA: begin
                aes_load_shift_nx = 1'b1;
                aes_din_nx        = data_nx[{cnt_nx, 3'b000} +: 8];
            end
            S_START: begin
                aes_staenc_nx = !dec_nx;
                aes_stadec_nx = dec_nx;
            end
            S_UNLOAD: begin
                aes_load_shift_nx = (unl_idx_nx < SHIFT_END);
            end
            default: begin
                aes_din_nx = 8'd0;
            end
        endcase
    end

    // state, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= 4'd0;
            wcnt           <= '0;
            key_q          <= '0;
            data_q         <= '0;
            dec_q          <= 1'b0;
            key_loaded     <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            busy           <= 1'b0;
            aes_din        <= 8'd0;
            aes_loadkey    <= 1'b0;
            aes_load_shift <= 1'b0;
            aes_staenc     <= 1'b0;
            aes_stadec     <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            wcnt           <= wcnt_nx;
            key_q          <= key_nx;
            data_q         <= data_nx;
            dec_q          <= dec_nx;
            key_loaded     <= key_loaded_nx;
            rsp_data       <= rsp_data_nx;
            rsp_err        <= rsp_err_nx;
            cmd_ready      <= cmd_ready_nx;
            rsp_valid      <= rsp_valid_nx;
            busy           <= busy_nx;
            aes_din        <= aes_din_nx;
            aes_loadkey    <= aes_loadkey_nx;
            aes_load_shift <= aes_load_shift_nx;
            aes_staenc     <= aes_staenc_nx;
            aes_stadec     <= aes_stadec_nx;
        end
    end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// tb_aes_seq_ctrl: directed plus randomized commands against aes_seq_ctrl,
// with a byte-serial core model that records what it is fed and returns a
// result block DOUT_LAT cycles after each unload shift.
module tb_aes_seq_ctrl;

    localparam int CORE_LAT = 13;
    localparam int DOUT_LAT = 1;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_dec, cmd_newkey;
    logic [127:0] cmd_key, cmd_data;
    logic         rsp_valid, rsp_ready, rsp_err, busy;
    logic [127:0] rsp_data;
    logic [7:0]   aes_din, aes_dout;
    logic         aes_loadkey, aes_load_shift, aes_staenc, aes_stadec;

    aes_seq_ctrl #(.CORE_LAT(CORE_LAT), .DOUT_LAT(DOUT_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dec(cmd_dec),
        .cmd_newkey(cmd_newkey), .cmd_key(cmd_key), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy),
        .aes_din(aes_din), .aes_loadkey(aes_loadkey), .aes_load_shift(aes_load_shift),
        .aes_staenc(aes_staenc), .aes_stadec(aes_stadec), .aes_dout(aes_dout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // core behaviour: the real AES pair for the reference vector, otherwise a
    // cheap keyed scramble that still depends on every key and data bit
    function automatic logic [127:0] core_fn(input logic [127:0] k, d, input logic dec);
        if (!dec && k == K0 && d == P0) return C0;
        if (dec && k == K0 && d == C0) return P0;
        if (!dec) return {d[63:0], d[127:64]} ^ k ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
        return d ^ ~k;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- core model and protocol monitor ----------------
    int           ncyc = 0;
    int           tot_key = 0, tot_data = 0, tot_start = 0, tot_ushift = 0;
    int           viol_both = 0, viol_din = 0, viol_start2 = 0;
    int           kidx = 0, didx = 0, ucnt = 0, start_n = 0;
    logic         prev_lk = 1'b0, prev_ld = 1'b0, unl = 1'b0, start_dec = 1'b0;
    logic [127:0] key_cap = '0, data_cap = '0, core_key = '0, res = '0;
    logic [8:0]   dq[$];
    logic [8:0]   ent;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            kidx = 0; didx = 0; ucnt = 0; unl = 1'b0;
            prev_lk = 1'b0; prev_ld = 1'b0;
            dq.delete();
            aes_dout = 8'd0;
        end else begin
            if (aes_loadkey && aes_load_shift) viol_both++;
            if (aes_staenc && aes_stadec) viol_start2++;
            if ((!aes_loadkey && !aes_load_shift) || unl)
                if (aes_din != 8'd0) viol_din++;
            ent = 9'd0;
            if (aes_loadkey) begin
                if (!prev_lk) kidx = 0;
                if (kidx < 16) key_cap[8*kidx +: 8] = aes_din;
                kidx++;
                tot_key++;
                if (kidx == 16) core_key = key_cap;
            end
            if (aes_load_shift && unl) begin
                ent = {1'b1, res[8*ucnt +: 8]};
                ucnt++;
                tot_ushift++;
                if (ucnt == 16) unl = 1'b0;
            end else if (aes_load_shift) begin
                if (!prev_ld) didx = 0;
                if (didx < 16) data_cap[8*didx +: 8] = aes_din;
                didx++;
                tot_data++;
            end
            if (aes_staenc || aes_stadec) begin
                tot_start++;
                start_dec = aes_stadec;
                start_n = ncyc;
                res = core_fn(core_key, data_cap, aes_stadec);
                unl = 1'b1;
                ucnt = 0;
            end
            prev_lk = aes_loadkey;
            prev_ld = aes_load_shift && !unl;
            dq.push_back(ent);
            if (dq.size() > DOUT_LAT) begin
                ent = dq.pop_front();
                aes_dout = ent[8] ? ent[7:0] : 8'($urandom);
            end
        end
    end

    // ---------------- checking helpers and reference state ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic         ref_loaded = 1'b0;
    logic [127:0] ref_key = '0;
    logic         e_nk, e_dec, e_err;
    logic [127:0] e_key, e_data, e_rsp;
    int           s_key, s_data, s_start, s_ushift, acc_n;

    task automatic send_cmd(input logic nk, input logic dec, input logic [127:0] k,
                            input logic [127:0] d, output int tries);
        logic r, acc;
        s_key = tot_key; s_data = tot_data; s_start = tot_start; s_ushift = tot_ushift;
        cmd_newkey = nk; cmd_dec = dec; cmd_key = k; cmd_data = d;
        cmd_valid = 1'b1;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 50) begin
            r = cmd_ready;
            @(posedge clk);
            tries++;
            if (r) acc = 1'b1;
            #1;
        end
        cmd_valid = 1'b0;
        acc_n = ncyc;
        chk("accept", {127'd0, acc}, 128'd1);
        chk("ready_drop", {127'd0, cmd_ready}, 128'd0);
        e_nk = nk; e_dec = dec; e_data = d;
        if (nk) begin
            ref_key = k;
            ref_loaded = 1'b1;
            e_err = 1'b0;
        end else begin
            e_err = !ref_loaded;
        end
        e_key = ref_key;
        e_rsp = e_err ? 128'd0 : core_fn(e_key, d, dec);
    endtask

    task automatic wait_rsp(input logic hold);
        int n, exp_lat;
        n = 1;
        while (!rsp_valid && n < 200) begin
            cmd_key = rand128(); cmd_data = rand128();
            cmd_dec = 1'($urandom); cmd_newkey = 1'($urandom);
            rsp_ready = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        rsp_ready = !hold;
        exp_lat = e_err ? 1 : (16 * int'(e_nk) + 17 + CORE_LAT + 16 + DOUT_LAT + 1);
        chk("rsp_valid_timeout", {127'd0, rsp_valid}, 128'd1);
        chk("latency", 128'(n), 128'(exp_lat));
        chk("rsp_err", {127'd0, rsp_err}, {127'd0, e_err});
        chk("rsp_data", rsp_data, e_rsp);
        chk("n_loadkey", 128'(tot_key - s_key), 128'((e_err || !e_nk) ? 0 : 16));
        chk("n_lddata", 128'(tot_data - s_data), 128'(e_err ? 0 : 16));
        chk("n_start", 128'(tot_start - s_start), 128'(e_err ? 0 : 1));
        chk("n_unload", 128'(tot_ushift - s_ushift), 128'(e_err ? 0 : 16));
        if (!e_err) begin
            if (e_nk) chk("key_bytes", key_cap, e_key);
            chk("data_bytes", data_cap, e_data);
            chk("start_dir", {127'd0, start_dec}, {127'd0, e_dec});
            chk("start_cycle", 128'(start_n - acc_n), 128'(16 * int'(e_nk) + 17));
        end
        chk("excl_strobes", 128'(viol_both), 128'd0);
        chk("din_idle", 128'(viol_din), 128'd0);
        chk("dual_start", 128'(viol_start2), 128'd0);
    endtask

    task automatic take_rsp();
        @(posedge clk);
        #1;
        chk("rsp_drop", {127'd0, rsp_valid}, 128'd0);
        chk("ready_back", {127'd0, cmd_ready}, 128'd1);
        chk("busy_idle", {127'd0, busy}, 128'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {cmd_ready, busy, rsp_valid, rsp_err, aes_din, aes_loadkey,
                  aes_load_shift, aes_staenc, aes_stadec},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk({tag, "_data"}, rsp_data, 128'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int tries;
        logic nk, dec;
        logic [127:0] k, d, held;

        rst = 1'b1; cmd_valid = 1'b0; cmd_dec = 1'b0; cmd_newkey = 1'b0;
        cmd_key = '0; cmd_data = '0; rsp_ready = 1'b1;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_ready", {126'd0, cmd_ready, busy}, {126'd0, 1'b1, 1'b0});

        // no key loaded yet
        send_cmd(1'b0, 1'b0, rand128(), rand128(), tries);
        wait_rsp(1'b0);
        take_rsp();

        // reference vector, encrypt with new key then decrypt with kept key
        send_cmd(1'b1, 1'b0, K0, P0, tries);
        wait_rsp(1'b0);
        take_rsp();
        send_cmd(1'b0, 1'b1, rand128(), C0, tries);
        wait_rsp(1'b0);
        take_rsp();

        // backpressure with a pending command behind the response
        send_cmd(1'b0, 1'b0, rand128(), rand128(), tries);
        wait_rsp(1'b1);
        held = e_rsp;
        s_key = tot_key; s_data = tot_data; s_start = tot_start; s_ushift = tot_ushift;
        k = rand128(); d = rand128();
        cmd_newkey = 1'b1; cmd_dec = 1'b1; cmd_key = k; cmd_data = d; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {127'd0, rsp_valid}, 128'd1);
            chk("bp_data", rsp_data, held);
            chk("bp_ready", {127'd0, cmd_ready}, 128'd0);
        end
        chk("bp_strobes", 128'(tot_key + tot_data + tot_start + tot_ushift),
            128'(s_key + s_data + s_start + s_ushift));
        rsp_ready = 1'b1;
        send_cmd(1'b1, 1'b1, k, d, tries);
        chk("bp_accept_edge", 128'(tries), 128'd2);
        wait_rsp(1'b0);
        take_rsp();

        // randomized commands
        for (int i = 0; i < 10; i++) begin
            nk = 1'($urandom);
            dec = 1'($urandom);
            k = rand128();
            d = rand128();
            send_cmd(nk, dec, k, d, tries);
            wait_rsp(1'b0);
            take_rsp();
        end

        // asynchronous reset in the middle of LDDATA
        send_cmd(1'b1, 1'b0, rand128(), rand128(), tries);
        repeat (20) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        ref_loaded = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_ready", {126'd0, cmd_ready, busy}, {126'd0, 1'b1, 1'b0});
        s_key = tot_key; s_start = tot_start;
        send_cmd(1'b0, 1'b0, rand128(), rand128(), tries);
        wait_rsp(1'b0);
        take_rsp();
        send_cmd(1'b1, 1'b1, rand128(), rand128(), tries);
        wait_rsp(1'b0);
        take_rsp();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
